// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative RISC-V M-extension multiply/divide unit, XLEN cycles per op.
// Optional ALU_MULDIV_EARLY_OUT_EN: special cases finish after one cycle instead of XLEN.
module alu_muldiv #(
  parameter int XLEN  = 64,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op0,
  input  logic [XLEN-1:0] op1,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  logic [2:0]        r_func3;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_p;
  logic              r_neg;
  logic              r_special;
  logic              r_dbz_pend;
  logic [XLEN-1:0]   r_spec_res;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_dbz;

  logic              w_sgn0;
  logic              w_sgn1;
  logic              w_s0;
  logic              w_s1;
  logic [XLEN-1:0]   w_abs0;
  logic [XLEN-1:0]   w_abs1;
  logic              w_dbz;
  logic              w_ovf;
  logic              w_early;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_step;
  logic [XLEN-1:0]   w_mulh_neg;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_div_raw;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_calc_res;

  // Signed: MULH, DIV, REM both operands; MULHSU only op0.
  assign w_sgn0 = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
  assign w_sgn1 = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
  assign w_s0   = w_sgn0 & op0[XLEN-1];
  assign w_s1   = w_sgn1 & op1[XLEN-1];
  assign w_abs0 = w_s0 ? -op0 : op0;
  assign w_abs1 = w_s1 ? -op1 : op1;

  assign w_dbz = func3[2] && (op1 == '0);
  assign w_ovf = func3[2] && !func3[0] && (op0 == MIN_NEG) && (op1 == '1);
  assign w_spec_res = w_dbz ? (func3[1] ? op0 : '1) :
                      w_ovf ? (func3[1] ? '0 : op0) : '0;

`ifdef ALU_MULDIV_EARLY_OUT_EN
  logic w_mul_zero;
  assign w_mul_zero = !func3[2] && ((op0 == '0) || (op1 == '0));
  assign w_early    = w_dbz | w_ovf | w_mul_zero;
`else
  assign w_early    = 1'b0;
`endif

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign w_mul_sum  = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_p[XLEN-1:1]};

  // Restoring division: {remainder, dividend/quotient} shift left one bit per step.
  assign w_shift    = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_diff[XLEN];
  assign w_div_next = {(w_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]), r_p[XLEN-2:0], w_qbit};

  assign w_step = r_func3[2] ? w_div_next : w_mul_next;

  // High half of the negated product: ~hi plus the carry out of negating lo.
  assign w_mulh_neg = ~w_step[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, (w_step[XLEN-1:0] == '0)};
  assign w_mul_res  = (r_func3[1:0] == 2'b00) ? w_step[XLEN-1:0] :
                      (r_neg ? w_mulh_neg : w_step[2*XLEN-1:XLEN]);
  assign w_div_raw  = r_func3[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];
  assign w_div_res  = r_neg ? -w_div_raw : w_div_raw;
  assign w_calc_res = r_func3[2] ? w_div_res : w_mul_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_func3      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_p          <= '0;
      r_neg        <= 1'b0;
      r_special    <= 1'b0;
      r_dbz_pend   <= 1'b0;
      r_spec_res   <= '0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_result     <= '0;
      r_dbz        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && !flush) begin
            r_func3     <= func3;
            r_a         <= w_abs0;
            r_b         <= w_abs1;
            r_p         <= {{XLEN{1'b0}}, (func3[2] ? w_abs0 : w_abs1)};
            r_neg       <= (func3[2] && func3[1]) ? w_s0 : (w_s0 ^ w_s1);
            r_special   <= w_dbz | w_ovf | w_early;
            r_dbz_pend  <= w_dbz;
            r_spec_res  <= w_spec_res;
            // Early-out runs a single CALC edge that writes the special result.
            r_cnt       <= w_early ? CNT_W'(1) : CNT_W'(XLEN);
            r_req_ready <= 1'b0;
            r_state     <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_p          <= w_step;
            r_result     <= r_special ? r_spec_res : w_calc_res;
            r_dbz        <= r_dbz_pend;
            r_resp_valid <= 1'b1;
            r_cnt        <= '0;
            r_state      <= DONE;
          end else begin
            r_p   <= w_step;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (flush || resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - scoreboard bench for alu_muldiv with directed M-extension vectors.
module tb_alu_muldiv;

`ifdef ALU_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  func3;
  logic [63:0] op0;
  logic [63:0] op1;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] result;
  logic        div_by_zero;

  alu_muldiv #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .func3(func3), .op0(op0), .op1(op1), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        d;
    bit          sp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[13];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  bit   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endfunction

  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] er, input logic ed, input int el, input bit push);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", req_ready, 1);
    func3 = f; op0 = a; op1 = b; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("accepted", req_ready, 0);
    if (push) begin
      e.res = er; e.dbz = ed; e.lat = el; e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: pops expectations on each response handshake, checks latency and hold stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
          if (resp_ready) begin
            chk("result", result, exp_q[0].res);
            chk("div_by_zero", 64'(div_by_zero), 64'(exp_q[0].dbz));
            void'(exp_q.pop_front());
          end else begin
            chk("hold_result", result, exp_q[0].res);
            chk("hold_req_ready", 64'(req_ready), 0);
          end
        end
      end
      prev_valid = resp_valid;
    end
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; func3 = '0; op0 = '0; op1 = '0;
    flush = 1'b0; resp_ready = 1'b1;

    vecs[0]  = '{3'b000, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b0, 1'b0};
    vecs[1]  = '{3'b011, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b0};
    vecs[5]  = '{3'b110, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[6]  = '{3'b101, 64'd100, 64'd7, 64'd14, 1'b0, 1'b0};
    vecs[7]  = '{3'b111, 64'd100, 64'd7, 64'd2, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1};
    vecs[9]  = '{3'b110, 64'd5, 64'd0, 64'd5, 1'b1, 1'b1};
    vecs[10] = '{3'b100, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1'b0, 1'b1};
    vecs[11] = '{3'b110, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b0, 1'b1};
    vecs[12] = '{3'b000, 64'd0, 64'd5, 64'd0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_div_by_zero", 64'(div_by_zero), 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].d,
            (vecs[i].sp && EARLY) ? 1 : 64, 1'b1);
      drain(300);
    end

    // Backpressure: hold the response for 10 cycles, then one handshake.
    resp_ready = 1'b0;
    issue(3'b101, 64'd100, 64'd7, 64'd14, 1'b0, 64, 1'b1);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_resp_valid_seen", 64'(resp_valid), 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_handshake", 64'(req_ready), 1);
    chk("valid_drop_after_handshake", 64'(resp_valid), 0);
    issue(3'b111, 64'd100, 64'd7, 64'd2, 1'b0, 64, 1'b1);
    drain(300);

    // Flush mid-divide: no response, ready again next cycle.
    issue(3'b101, 64'd1000, 64'd3, 64'd0, 1'b0, 64, 1'b0);
    repeat (19) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_req_ready", 64'(req_ready), 1);
    chk("flush_resp_valid", 64'(resp_valid), 0);
    repeat (70) @(negedge clk);

    // Asynchronous reset mid-multiply.
    issue(3'b000, 64'd9, 64'd9, 64'd0, 1'b0, 64, 1'b0);
    repeat (30) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 0);
    chk("arst_result", result, 0);
    chk("arst_div_by_zero", 64'(div_by_zero), 0);
    chk("arst_req_ready", 64'(req_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    issue(3'b000, 64'd3, 64'd4, 64'd12, 1'b0, 64, 1'b1);
    drain(300);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
